// File: rtl/kernel2_mul_acc_pipe.sv
// Pipelined multiplier / multiply-accumulate with valid-ready handshake.
// NUM_STAGE registers deep; the last register is the accumulator that drives dout.
module kernel2_mul_acc_pipe #(
  parameter int A_W       = 13,
  parameter int B_W       = 11,
  parameter int P_W       = 24,
  parameter int ACC_W     = 32,
  parameter int NUM_STAGE = 3,
  parameter int SIGNED    = 0
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  input  logic             acc_en,
  input  logic             acc_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] dout,
  output logic             ovf
);

  localparam int FULL_W = A_W + B_W;

  typedef struct packed {
    logic           vld;
    logic           acc_en;
    logic           acc_first;
    logic [P_W-1:0] prod;
  } beat_t;

  logic              advance;
  logic [FULL_W-1:0] a_x;
  logic [FULL_W-1:0] b_x;
  logic [FULL_W-1:0] full_prod;
  beat_t             in_beat;
  beat_t             fin_beat;
  logic [ACC_W-1:0]  ext;
  logic [ACC_W:0]    sum;
  logic              add_ovf;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operands are widened to the full product width first, so the truncated
  // product is correct two's-complement for signed mode as well.
  always_comb begin
    a_x       = (SIGNED != 0) ? FULL_W'($signed(din0)) : FULL_W'(din0);
    b_x       = (SIGNED != 0) ? FULL_W'($signed(din1)) : FULL_W'(din1);
    full_prod = a_x * b_x;

    in_beat.vld       = in_valid;
    in_beat.acc_en    = acc_en;
    in_beat.acc_first = acc_first;
    in_beat.prod      = (SIGNED != 0) ? P_W'($signed(full_prod)) : P_W'(full_prod);
  end

  if (NUM_STAGE == 1) begin : g_direct
    assign fin_beat = in_beat;
  end else begin : g_pipe
    beat_t stg [NUM_STAGE-1];

    // NOTE: registers use non-blocking assignment so every stage samples the
    // previous stage's old value on the same edge; blocking would collapse the pipe.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < NUM_STAGE-1; i++) stg[i] <= '0;
      end else if (advance) begin
        stg[0] <= in_beat;
        for (int i = 1; i < NUM_STAGE-1; i++) stg[i] <= stg[i-1];
      end
    end

    assign fin_beat = stg[NUM_STAGE-2];
  end

  always_comb begin
    ext = (SIGNED != 0) ? ACC_W'($signed(fin_beat.prod)) : ACC_W'(fin_beat.prod);
    sum = {1'b0, dout} + {1'b0, ext};
    // NOTE: both branches assign add_ovf, so no latch can be inferred here.
    if (SIGNED != 0) begin
      add_ovf = (dout[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != dout[ACC_W-1]);
    end else begin
      add_ovf = sum[ACC_W];
    end
  end

  // A bubble only clears out_valid; dout/ovf hold so an accumulation spans gaps.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= fin_beat.vld;
      if (fin_beat.vld) begin
        if (fin_beat.acc_en && !fin_beat.acc_first) begin
          dout <= sum[ACC_W-1:0];
          ovf  <= ovf || add_ovf;
        end else begin
          dout <= ext;
          ovf  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel2_mul_acc_pipe.sv
// Bench for kernel2_mul_acc_pipe: three instances (unsigned/32, signed/32,
// unsigned/24) share clock and reset; a reference model fills per-instance queues.
module tb_kernel2_mul_acc_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [12:0] din0      [3];
  logic [10:0] din1      [3];
  logic        acc_en    [3];
  logic        acc_first [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        ovf       [3];
  logic [31:0] dout_a;
  logic [31:0] dout_b;
  logic [23:0] dout_c;
  logic [31:0] dout_w    [3];

  int          dut_sgn [3] = '{0, 1, 0};
  int          dut_aw  [3] = '{32, 32, 24};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          last_acc [3];
  longint      m_acc    [3];
  bit          m_ovf    [3];
  logic [32:0] sb     [3][$];
  logic [32:0] log_v  [3][$];
  int          log_c  [3][$];

  always #5 clk = ~clk;

  assign dout_w[0] = dout_a;
  assign dout_w[1] = dout_b;
  assign dout_w[2] = {8'h00, dout_c};

  kernel2_mul_acc_pipe u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .din0(din0[0]), .din1(din1[0]), .acc_en(acc_en[0]), .acc_first(acc_first[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .dout(dout_a), .ovf(ovf[0])
  );

  kernel2_mul_acc_pipe #(.SIGNED(1)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .din0(din0[1]), .din1(din1[1]), .acc_en(acc_en[1]), .acc_first(acc_first[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .dout(dout_b), .ovf(ovf[1])
  );

  kernel2_mul_acc_pipe #(.ACC_W(24)) u_dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .din0(din0[2]), .din1(din1[2]), .acc_en(acc_en[2]), .acc_first(acc_first[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .dout(dout_c), .ovf(ovf[2])
  );

  function automatic longint mask(input int d);
    return (longint'(1) << dut_aw[d]) - 1;
  endfunction

  function automatic longint to_s(input longint v, input int w);
    return (v >= (longint'(1) << (w-1))) ? v - (longint'(1) << w) : v;
  endfunction

  // Product truncated to 24 bits, then extended and reduced modulo 2^ACC_W.
  function automatic longint model_ext(input int d, input int a, input int b);
    longint sa = a;
    longint sb_ = b;
    longint p;
    if (dut_sgn[d] != 0) begin
      if (sa >= 4096) sa -= 8192;
      if (sb_ >= 1024) sb_ -= 2048;
    end
    p = (sa * sb_) & 64'hFFFFFF;
    if (dut_sgn[d] != 0 && p >= 64'h800000) p -= 64'h1000000;
    return p & mask(d);
  endfunction

  task automatic model_accept(input int d);
    longint e;
    longint s;
    bit     o;
    e = model_ext(d, int'(din0[d]), int'(din1[d]));
    if (acc_en[d] && !acc_first[d]) begin
      if (dut_sgn[d] != 0) begin
        s = to_s(m_acc[d], dut_aw[d]) + to_s(e, dut_aw[d]);
        o = (s > (longint'(1) << (dut_aw[d]-1)) - 1) || (s < -(longint'(1) << (dut_aw[d]-1)));
      end else begin
        s = m_acc[d] + e;
        o = (s > mask(d));
      end
      m_acc[d] = s & mask(d);
      m_ovf[d] = m_ovf[d] | o;
    end else begin
      m_acc[d] = e;
      m_ovf[d] = 1'b0;
    end
    sb[d].push_back({m_ovf[d], m_acc[d][31:0]});
  endtask

  // One clock: record handshakes as they will be sampled, then take the edge.
  task automatic cycle();
    logic [32:0] e;
    #1;
    for (int d = 0; d < 3; d++) begin
      last_acc[d] = in_valid[d] && in_ready[d];
      if (out_valid[d] && out_ready[d]) begin
        n_tests++;
        if (sb[d].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out%0d: got dout=%0h with no beat pending", d, dout_w[d]);
        end else begin
          e = sb[d].pop_front();
          if ({ovf[d], dout_w[d]} !== e) begin
            n_fail++;
            $display("FAIL sb%0d: got dout=%0h ovf=%0b expected dout=%0h ovf=%0b",
                     d, dout_w[d], ovf[d], e[31:0], e[32]);
          end
        end
        log_v[d].push_back({ovf[d], dout_w[d]});
        log_c[d].push_back(cyc);
      end
      if (last_acc[d]) model_accept(d);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int d, input int a, input int b, input bit en, input bit first);
    int guard = 0;
    in_valid[d] = 1'b1;
    din0[d] = 13'(a);
    din1[d] = 11'(b);
    acc_en[d] = en;
    acc_first[d] = first;
    do begin
      cycle();
      guard++;
    end while (!last_acc[d] && guard < 50);
    in_valid[d] = 1'b0;
    n_tests++;
    if (!last_acc[d]) begin
      n_fail++;
      $display("FAIL accept_timeout%0d: got no accept in %0d cycles, required accept", d, guard);
    end
  endtask

  task automatic drain(input int d);
    int guard = 0;
    while ((sb[d].size() > 0 || out_valid[d]) && guard < 100) begin
      cycle();
      guard++;
    end
    n_tests++;
    if (sb[d].size() != 0) begin
      n_fail++;
      $display("FAIL drain%0d: got %0d beats still pending, required 0", d, sb[d].size());
    end
  endtask

  task automatic clear_log(input int d);
    log_v[d].delete();
    log_c[d].delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; din0[d] = '0; din1[d] = '0;
      acc_en[d] = 1'b0; acc_first[d] = 1'b0; out_ready[d] = 1'b1;
      m_acc[d] = 0; m_ovf[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({out_valid[d], ovf[d], dout_w[d], in_ready[d]} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_state%0d: got out_valid=%0b ovf=%0b dout=%0h in_ready=%0b, required 0 0 0 1",
                 d, out_valid[d], ovf[d], dout_w[d], in_ready[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_latency();
    int lat = 1;
    send(0, 8191, 2047, 1'b0, 1'b0);
    while (!out_valid[0] && lat < 20) begin
      cycle();
      lat++;
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required 3", lat);
    end
    n_tests++;
    if ({ovf[0], dout_w[0]} !== {1'b0, 32'd16766977}) begin
      n_fail++;
      $display("FAIL full_scale: got dout=%0d ovf=%0b, required 16766977 0", dout_w[0], ovf[0]);
    end
    cycle();
    n_tests++;
    if (out_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: got out_valid=%0b one cycle later, required 0", out_valid[0]);
    end
    drain(0);
  endtask

  task automatic test_signed();
    logic [32:0] exp_v [2];
    exp_v[0] = {1'b0, 32'hFFFFFFFB};
    exp_v[1] = {1'b0, 32'd4194304};
    clear_log(1);
    send(1, 13'h1FFF, 5, 1'b0, 1'b0);
    send(1, 13'h1000, 11'h400, 1'b0, 1'b0);
    drain(1);
    n_tests++;
    if (log_v[1].size() != 2) begin
      n_fail++;
      $display("FAIL signed_count: got %0d outputs, required 2", log_v[1].size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (log_v[1][i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL signed_val%0d: got %0h, required %0h", i, log_v[1][i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_mac(input bit bubble);
    int exp_v [4] = '{12, 42, 98, 99};
    int gap;
    clear_log(0);
    send(0, 3, 4, 1'b1, 1'b1);
    send(0, 5, 6, 1'b1, 1'b0);
    if (bubble) cycle();
    send(0, 7, 8, 1'b1, 1'b0);
    send(0, 1, 1, 1'b1, 1'b0);
    drain(0);
    n_tests++;
    if (log_v[0].size() != 4) begin
      n_fail++;
      $display("FAIL mac_count(bubble=%0b): got %0d outputs, required 4", bubble, log_v[0].size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (log_v[0][i] !== {1'b0, 32'(exp_v[i])}) begin
          n_fail++;
          $display("FAIL mac_val%0d(bubble=%0b): got %0d, required %0d", i, bubble, log_v[0][i][31:0], exp_v[i]);
        end
        if (i > 0) begin
          gap = (bubble && i == 2) ? 2 : 1;
          n_tests++;
          if (log_c[0][i] - log_c[0][i-1] != gap) begin
            n_fail++;
            $display("FAIL mac_spacing%0d(bubble=%0b): got %0d cycles, required %0d",
                     i, bubble, log_c[0][i] - log_c[0][i-1], gap);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          i = 1;
    int          t = 0;
    int          stalls = 0;
    logic [31:0] held = '0;
    bit          was_stalled = 1'b0;
    clear_log(0);
    while ((i <= 6 || sb[0].size() > 0) && t < 80) begin
      out_ready[0] = !(t >= 3 && t < 8);
      in_valid[0]  = (i <= 6);
      din0[0] = 13'(i);
      din1[0] = 11'(i + 1);
      acc_en[0] = 1'b0;
      acc_first[0] = 1'b0;
      #1;
      if (out_valid[0] && !out_ready[0]) begin
        stalls++;
        n_tests++;
        if (in_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: got in_ready=%0b at t=%0d, required 0", in_ready[0], t);
        end
        if (was_stalled) begin
          n_tests++;
          if (dout_w[0] !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got dout=%0d at t=%0d, required %0d", dout_w[0], t, held);
          end
        end
        held = dout_w[0];
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      cycle();
      if (last_acc[0]) i++;
      t++;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    n_tests++;
    if (stalls != 5) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d stalled cycles, required 5", stalls);
    end
    n_tests++;
    if (log_v[0].size() != 6) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, required 6", log_v[0].size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (log_v[0][k] !== {1'b0, 32'((k + 1) * (k + 2))}) begin
          n_fail++;
          $display("FAIL bp_val%0d: got %0d, required %0d", k, log_v[0][k][31:0], (k + 1) * (k + 2));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [32:0] exp_v [3];
    exp_v[0] = {1'b0, 32'd16766977};
    exp_v[1] = {1'b1, 32'd16756738};
    exp_v[2] = {1'b0, 32'd1};
    clear_log(2);
    send(2, 8191, 2047, 1'b1, 1'b1);
    send(2, 8191, 2047, 1'b1, 1'b0);
    send(2, 1, 1, 1'b1, 1'b1);
    drain(2);
    n_tests++;
    if (log_v[2].size() != 3) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d outputs, required 3", log_v[2].size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (log_v[2][i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL ovf_val%0d: got dout=%0d ovf=%0b, required dout=%0d ovf=%0b",
                   i, log_v[2][i][31:0], log_v[2][i][32], exp_v[i][31:0], exp_v[i][32]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int lat = 1;
    send(0, 10, 10, 1'b0, 1'b0);
    send(0, 2, 2, 1'b0, 1'b0);
    send(0, 3, 3, 1'b0, 1'b0);
    n_tests++;
    if (out_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got out_valid=%0b, required 1", out_valid[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid[0], ovf[0], dout_w[0]} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got out_valid=%0b ovf=%0b dout=%0h, required 0 0 0",
               out_valid[0], ovf[0], dout_w[0]);
    end
    for (int d = 0; d < 3; d++) begin
      sb[d].delete();
      m_acc[d] = 0;
      m_ovf[d] = 1'b0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_tests++;
      if (out_valid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_beat: got out_valid=%0b %0d cycles after release, required 0", out_valid[0], k);
      end
    end
    // First beat after reset accumulates onto zero.
    send(0, 3, 4, 1'b1, 1'b0);
    while (!out_valid[0] && lat < 20) begin
      cycle();
      lat++;
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d cycles, required 3", lat);
    end
    n_tests++;
    if ({ovf[0], dout_w[0]} !== {1'b0, 32'd12}) begin
      n_fail++;
      $display("FAIL post_reset_acc: got dout=%0d ovf=%0b, required 12 0", dout_w[0], ovf[0]);
    end
    drain(0);
  endtask

  initial begin
    test_reset();
    test_unsigned_latency();
    test_signed();
    test_mac(1'b0);
    test_mac(1'b1);
    test_backpressure();
    test_overflow();
    test_reset_midrun();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (sb[d].size() != 0) begin
        n_fail++;
        $display("FAIL leftover%0d: got %0d pending beats, required 0", d, sb[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kernel2_mul_acc_pipe.md
Name: kernel2_mul_acc_pipe

Overview:
- Parametrised, pipelined successor to the kernel's fixed combinational 13x11->24 multiplier cores.
- Adds configurable operand/product widths, a signed/unsigned mode, and NUM_STAGE register stages.
- Adds a valid/ready handshake with backpressure stall, and an optional multiply-accumulate mode with a sticky overflow flag.
- Instantiated by kernel2 datapaths wherever a dot-product or MAC loop needs to be retimed.

Parameters:
- A_W, 13, width of din0.
- B_W, 11, width of din1.
- P_W, 24, product width. The full product is computed at A_W+B_W bits; the low P_W bits are kept if P_W is smaller.
- ACC_W, 32, accumulator/output width. Must be >= P_W.
- NUM_STAGE, 3, total latency in cycles. Must be >= 1. The final stage is always the accumulator/output register.
- SIGNED, 0, operand interpretation. 0 = unsigned with zero-extend; 1 = two's-complement with sign-extend.

Ports:
- ap_clk, in, 1, clock; all state is on the rising edge.
- ap_rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block can accept a beat this cycle.
- din0, in, A_W, operand A.
- din1, in, B_W, operand B.
- acc_en, in, 1, beat joins an accumulation; travels with the beat.
- acc_first, in, 1, beat starts a new accumulation (only meaningful when acc_en=1); travels with the beat.
- out_valid, out, 1, dout is valid.
- out_ready, in, 1, consumer accepts dout.
- dout, out, ACC_W, result.
- ovf, out, 1, sticky accumulation overflow; valid together with dout.

Behaviour:
- Reset (asynchronous assert on ap_rst_n=0):
  - All stage valid bits, out_valid, dout, ovf and the accumulator go to 0.
  - In-flight beats are discarded.
  - Reset release is synchronous to ap_clk; the first accept is possible on the first edge after release.
- Advance and handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance, combinational.
  - A beat is accepted on an edge where in_valid & in_ready.
  - All stages shift together only when advance=1. When advance=0, every stage, dout and ovf hold.
  - Bubbles are not collapsed.
- Product path:
  - Stage 1 registers the P_W product with its valid, acc_en and acc_first bits.
  - Stages 2..NUM_STAGE-1 are plain delay registers.
  - For NUM_STAGE=1, the product is formed combinationally into the final register.
  - Latency is exactly NUM_STAGE cycles from accept to out_valid when out_ready stays 1.
  - Throughput is 1 beat/cycle.
- Final stage: when a valid beat enters (advance=1), with ext = product sign/zero-extended to ACC_W:
  - acc_en=0: dout = ext, ovf = 0.
  - acc_en=1, acc_first=1: dout = ext, ovf = 0.
  - acc_en=1, acc_first=0: dout = dout + ext, wrapping modulo 2^ACC_W. ovf = ovf | overflow.
    - Overflow definition, SIGNED=0: carry out of bit ACC_W-1.
    - Overflow definition, SIGNED=1: both addends have the same sign and the sum sign differs.
  - out_valid = 1.
- Bubble into final stage (advance=1): out_valid = 0; dout and ovf hold, so an accumulation survives bubbles.
- Simultaneous accept and emit on the same edge is legal and must not drop or duplicate beats.
- acc_en=1 with acc_first=0 as the first beat after reset accumulates onto 0.

Test Plan:
- Unsigned full-scale, defaults, out_ready=1. din0=8191, din1=2047 -> after exactly 3 cycles, out_valid=1 for 1 cycle, dout=16766977, ovf=0.
- Signed, SIGNED=1. din0=13'h1FFF (-1), din1=11'd5 -> dout=32'hFFFFFFFB. Then din0=13'h1000 (-4096), din1=11'h400 (-1024) -> dout=4194304.
- MAC run with 4 back-to-back beats, acc_en=1, acc_first only on the first: (3,4), (5,6), (7,8), (1,1) -> dout sequence 12, 42, 98, 99 on consecutive cycles. A bubble inserted between beats 2 and 3 -> same values, with one out_valid=0 gap.
- Backpressure: stream 6 beats (i, i+1) for i=1..6 while out_ready is low for 5 cycles mid-stream.
  - in_ready falls in the same cycle out_valid=1 & out_ready=0.
  - All 6 products 2, 6, 12, 20, 30, 42 appear in order, none lost or duplicated.
  - dout is stable while stalled.
- Overflow, ACC_W=24, SIGNED=0. Two MAC beats of 8191x2047 -> second dout=16756738 with ovf=1. A following beat with acc_first=1 clears ovf to 0.
- Reset mid-run: pull ap_rst_n low with 2 beats in flight and out_valid=1 -> out_valid, dout and ovf are 0 immediately, asynchronously. No stale beat appears after release, and the next beat's latency is again NUM_STAGE.
